// File: rtl/wave_voice_mixer_if.sv
// Control/sample bus between the mixer and its host: per-voice tuning inputs,
// sample request, and the mixed-sample output with its status flags.
interface wave_voice_mixer_if #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 16,
  parameter int unsigned OUT_W      = 8
);
  logic                          sample_tick;
  logic                          phase_clear;
  logic [NUM_VOICES*PHASE_W-1:0] tune;
  logic [NUM_VOICES*2-1:0]       mode;
  logic [NUM_VOICES*OUT_W-1:0]   duty;
  logic [OUT_W-1:0]              wave_out;
  logic                          wave_valid;
  logic                          busy;
  logic                          overrun;

  modport master (
    output sample_tick, phase_clear, tune, mode, duty,
    input  wave_out, wave_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, phase_clear, tune, mode, duty,
    output wave_out, wave_valid, busy, overrun
  );
endinterface

// File: rtl/wave_voice_mixer.sv
// Multi-voice phase-accumulator oscillator bank; each sample tick sweeps the
// voices one per clock and emits their floor-averaged mix with a valid strobe.
module wave_voice_mixer #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 16,
  parameter int unsigned OUT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  wave_voice_mixer_if.slave  bus
);
  localparam int unsigned LOG2  = $clog2(NUM_VOICES);
  localparam int unsigned IDX_W = (LOG2 == 0) ? 1 : LOG2;
  localparam int unsigned ACC_W = OUT_W + LOG2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   wave_q, wave_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];

  logic [PHASE_W-1:0] tune_a [NUM_VOICES];
  logic [1:0]         mode_a [NUM_VOICES];
  logic [OUT_W-1:0]   duty_a [NUM_VOICES];

  logic [PHASE_W-1:0] phase_cur;
  logic [PHASE_W-1:0] tune_cur;
  logic [1:0]         mode_cur;
  logic [OUT_W-1:0]   duty_cur;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-1:0]   t;
  logic [OUT_W-1:0]   w;

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      tune_a[v] = bus.tune[v*PHASE_W +: PHASE_W];
      mode_a[v] = bus.mode[v*2 +: 2];
      duty_a[v] = bus.duty[v*OUT_W +: OUT_W];
    end
  end

  // Waveform of the voice under the sweep pointer, from its pre-increment phase.
  always_comb begin
    phase_cur = phase_q[idx_q];
    tune_cur  = tune_a[idx_q];
    mode_cur  = mode_a[idx_q];
    duty_cur  = duty_a[idx_q];
    p         = phase_cur[PHASE_W-1 -: OUT_W];
    t         = {p[OUT_W-2:0], 1'b0};
    case (mode_cur)
      2'b01:   w = p[OUT_W-1] ? ~t : t;
      2'b10:   w = p;
      2'b11:   w = (p < duty_cur) ? '1 : '0;
      default: w = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    wave_d    = wave_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    phase_d   = phase_q;

    case (state_q)
      IDLE: begin
        if (bus.sample_tick) begin
          state_d = RUN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d          = acc_q + ACC_W'(w);
        phase_d[idx_q] = (mode_cur == 2'b00) ? '0 : phase_cur + tune_cur;
        idx_d          = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        wave_d  = OUT_W'(acc_q >> LOG2);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.sample_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // Clearing overrides the RUN-cycle increment but leaves the sweep running.
    if (bus.phase_clear) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase_d[v] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      wave_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      wave_q    <= wave_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        phase_q[v] <= phase_d[v];
      end
    end
  end

  assign bus.wave_out   = wave_q;
  assign bus.wave_valid = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_wave_voice_mixer.sv
// Bench for wave_voice_mixer: directed and random voice settings compared
// against an arithmetic model of the oscillators and the averaging mixer.
module tb_wave_voice_mixer;
  localparam int unsigned NV = 4;
  localparam int unsigned PW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned M  = 1 << OW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_voice_mixer_if #(.NUM_VOICES(NV), .PHASE_W(PW), .OUT_W(OW)) bus ();

  wave_voice_mixer #(.NUM_VOICES(NV), .PHASE_W(PW), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned tune_v  [NV];
  int unsigned mode_v  [NV];
  int unsigned duty_v  [NV];
  int unsigned m_phase [NV];

  task automatic apply_cfg();
    for (int v = 0; v < NV; v++) begin
      bus.tune[v*PW +: PW] = PW'(tune_v[v]);
      bus.mode[v*2 +: 2]   = 2'(mode_v[v]);
      bus.duty[v*OW +: OW] = OW'(duty_v[v]);
    end
  endtask

  task automatic set_all(input int unsigned md, input int unsigned tn, input int unsigned dt);
    for (int v = 0; v < NV; v++) begin
      mode_v[v] = md; tune_v[v] = tn; duty_v[v] = dt;
    end
    apply_cfg();
  endtask

  function automatic int unsigned voice_w(int unsigned ph, int unsigned md, int unsigned dt);
    int unsigned pv;
    pv = ph >> (PW - OW);
    case (md)
      1: return (pv < M/2) ? 2*pv : 2*M - 1 - 2*pv;
      2: return pv;
      3: return (pv < dt) ? M - 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_sample(output int unsigned e);
    int unsigned sum;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      sum += voice_w(m_phase[v], mode_v[v], duty_v[v]);
      m_phase[v] = (mode_v[v] == 0) ? 0 : (m_phase[v] + tune_v[v]) % (1 << PW);
    end
    e = sum / NV;
  endtask

  task automatic model_clear();
    for (int v = 0; v < NV; v++) m_phase[v] = 0;
  endtask

  task automatic run_sample(output int unsigned got, output int unsigned lat);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    lat = 0;
    while (bus.wave_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = bus.wave_out;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_tick = 1'b0;
    bus.phase_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      bus.sample_tick = 1'($urandom);
      bus.phase_clear = 1'($urandom);
      bus.tune = {$urandom, $urandom};
      bus.mode = 8'($urandom);
      bus.duty = $urandom;
      @(negedge clk);
    end
    total++; if (bus.wave_out !== 8'h00) begin bad++; $display("FAIL reset_wave_out got=%0h exp=0", bus.wave_out); end
    total++; if (bus.wave_valid !== 1'b0) begin bad++; $display("FAIL reset_wave_valid got=%b exp=0", bus.wave_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    bus.sample_tick = 1'b0;
    bus.phase_clear = 1'b0;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_sawtooth();
    int unsigned got, lat, e;
    do_reset();
    set_all(0, 0, 0);
    mode_v[0] = 2; tune_v[0] = 16'h1000;
    apply_cfg();
    for (int n = 0; n < 16; n++) begin
      run_sample(got, lat);
      model_sample(e);
      total++; if (lat !== 5) begin bad++; $display("FAIL saw_latency n=%0d got=%0d exp=5", n, lat); end
      total++; if (got !== e) begin bad++; $display("FAIL saw_sample n=%0d got=%0h exp=%0h", n, got, e); end
      @(negedge clk);
      total++; if (bus.wave_valid !== 1'b0) begin bad++; $display("FAIL saw_valid_width n=%0d got=%b exp=0", n, bus.wave_valid); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_pulse_triangle();
    int unsigned got, lat, e;
    do_reset();
    set_all(3, 16'h4000, 8'h80);
    for (int n = 0; n < 8; n++) begin
      run_sample(got, lat);
      model_sample(e);
      total++; if (got !== e) begin bad++; $display("FAIL pulse_sample n=%0d got=%0h exp=%0h", n, got, e); end
    end
    do_reset();
    set_all(0, 0, 0);
    mode_v[0] = 1; tune_v[0] = 16'h4000;
    apply_cfg();
    for (int n = 0; n < 8; n++) begin
      run_sample(got, lat);
      model_sample(e);
      total++; if (got !== e) begin bad++; $display("FAIL tri_sample n=%0d got=%0h exp=%0h", n, got, e); end
    end
  endtask

  task automatic test_overrun();
    int unsigned nval, vcyc, got, lat;
    do_reset();
    set_all(0, 0, 0);
    mode_v[0] = 2; tune_v[0] = 16'h1000;
    apply_cfg();
    nval = 0; vcyc = 0;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    @(negedge clk);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    for (int c = 3; c < 15; c++) begin
      @(negedge clk);
      if (bus.wave_valid === 1'b1) begin nval++; vcyc = c; end
    end
    total++; if (nval !== 1) begin bad++; $display("FAIL overrun_valid_count got=%0d exp=1", nval); end
    total++; if (vcyc !== 5) begin bad++; $display("FAIL overrun_valid_cycle got=%0d exp=5", vcyc); end
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", bus.overrun); end
    run_sample(got, lat);
    repeat (4) @(negedge clk);
    total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b exp=1", bus.overrun); end
    do_reset();
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_cleared got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_reset_midsweep();
    int unsigned nval, got, lat, e;
    do_reset();
    set_all(2, 16'h4000, 0);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    nval = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.wave_valid === 1'b1) nval++;
    end
    total++; if (nval !== 0) begin bad++; $display("FAIL midrst_valid_count got=%0d exp=0", nval); end
    model_clear();
    for (int n = 0; n < 3; n++) begin
      run_sample(got, lat);
      model_sample(e);
      total++; if (got !== e) begin bad++; $display("FAIL midrst_sample n=%0d got=%0h exp=%0h", n, got, e); end
    end
  endtask

  task automatic test_phase_clear();
    int unsigned got, lat, e;
    do_reset();
    set_all(0, 0, 0);
    mode_v[0] = 2; tune_v[0] = 16'h1000;
    apply_cfg();
    for (int n = 0; n < 8; n++) begin
      run_sample(got, lat);
      model_sample(e);
    end
    bus.phase_clear = 1'b1;
    @(negedge clk);
    bus.phase_clear = 1'b0;
    model_clear();
    run_sample(got, lat);
    model_sample(e);
    total++; if (got !== e) begin bad++; $display("FAIL clear_sample got=%0h exp=%0h", got, e); end
    tune_v[0] = 16'hFFFF;
    apply_cfg();
    for (int n = 0; n < 6; n++) begin
      run_sample(got, lat);
      model_sample(e);
      total++; if (got !== e) begin bad++; $display("FAIL wrap_sample n=%0d got=%0h exp=%0h", n, got, e); end
    end
  endtask

  task automatic test_random();
    int unsigned got, lat, e;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      for (int v = 0; v < NV; v++) begin
        tune_v[v] = $urandom % (1 << PW);
        mode_v[v] = $urandom_range(3, 0);
        duty_v[v] = $urandom % M;
      end
      apply_cfg();
      run_sample(got, lat);
      model_sample(e);
      total++; if (lat !== NV + 1) begin bad++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, NV + 1); end
      total++; if (got !== e) begin bad++; $display("FAIL rand_sample n=%0d got=%0h exp=%0h", n, got, e); end
      if (($urandom % 2) == 0) begin
        @(negedge clk);
        total++; if (bus.wave_valid !== 1'b0) begin bad++; $display("FAIL rand_valid_width n=%0d got=%b exp=0", n, bus.wave_valid); end
      end
    end
  endtask

  initial begin
    bus.sample_tick = 1'b0;
    bus.phase_clear = 1'b0;
    bus.tune = '0;
    bus.mode = '0;
    bus.duty = '0;
    for (int v = 0; v < NV; v++) begin
      tune_v[v] = 0; mode_v[v] = 0; duty_v[v] = 0; m_phase[v] = 0;
    end
    @(negedge clk);
    test_reset();
    test_sawtooth();
    test_pulse_triangle();
    test_overrun();
    test_reset_midsweep();
    test_phase_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wave_voice_mixer.md
# wave_voice_mixer

Parametrised multi-voice successor to the single-channel waveshaper. It contains NUM_VOICES independent phase-accumulator oscillators, each with its own tuning word, waveform mode and pulse duty. On each sample tick it sweeps the voices one per clock, mixes them into a single averaged OUT_W-bit sample, and presents that sample with a one-cycle valid strobe to the downstream PWM/DAC stage.

## Interface
- NUM_VOICES, default 4: voice count; must be a power of two, ≥1. L = log2(NUM_VOICES).
- PHASE_W, default 16: phase accumulator and tuning word width. Must be ≥ OUT_W.
- OUT_W, default 8: per-voice and output sample width. Must be ≥2.
- clk  in  1  system clock. One clock domain; reset is synchronous, active-high.
- rst  in  1  synchronous active-high reset.
- sample_tick  in  1  single-cycle request to produce one sample.
- phase_clear  in  1  synchronously zeroes all voice phases.
- tune  in  NUM_VOICES*PHASE_W  per-voice phase increment; voice v uses bits [v*PHASE_W +: PHASE_W].
- mode  in  NUM_VOICES*2  per-voice mode: 00 silent, 01 triangle, 10 sawtooth, 11 pulse.
- duty  in  NUM_VOICES*OUT_W  per-voice pulse threshold.
- wave_out  out  OUT_W  mixed sample; holds its value between valid strobes.
- wave_valid  out  1  high for exactly one cycle when wave_out updates.
- busy  out  1  high while a sweep is in progress (state ≠ IDLE).
- overrun  out  1  sticky; set when sample_tick arrives while busy.

## Operation
- FSM states: IDLE, RUN, DONE. There is a voice index idx (L bits, min 1) and an accumulator acc (OUT_W+L bits).
- IDLE: if sample_tick=1, go to RUN with idx←0 and acc←0.
- RUN: each cycle processes voice idx:
  - acc ← acc + w(idx).
  - phase[idx] ← phase[idx] + tune[idx], mod 2^PHASE_W.
  - If mode[idx]=00, phase[idx] ← 0 instead.
  - idx ← idx+1.
  - When idx = NUM_VOICES−1, go to DONE.
- DONE: wave_out ← acc >> L; wave_valid ← 1; go to IDLE.
- tune, mode and duty are read live during each voice's RUN cycle. They are not latched.
- Waveform w(v): p = phase[v][PHASE_W-1 -: OUT_W], t = {p[OUT_W-2:0], 1'b0}.
  - 00: w = 0.
  - 01: w = p[OUT_W-1] ? ~t : t.
  - 10: w = p.
  - 11: w = (p < duty[v]) ? 2^OUT_W−1 : 0.
- w always uses the phase before that cycle's increment.
- Mixing: acc cannot overflow. The result is an exact floor average, so no saturation is needed.
- sample_tick while busy: the tick is ignored, overrun←1. overrun clears only on rst.
- phase_clear: all phases←0 at that edge. It takes priority over any increment on the same edge. It does not abort or restart a sweep; acc is unaffected.
- rst, including mid-sweep: state←IDLE, idx←0, acc←0, all phases←0, wave_out←0, wave_valid←0, overrun←0. A sweep interrupted by rst emits no valid.

## Timing
- Reset values: wave_out=0, wave_valid=0, busy=0, overrun=0.
- sample_tick sampled at edge E0:
  - RUN occupies edges E1…E_N.
  - DONE registers the output at edge E_(N+1).
  - wave_valid is high during the cycle after E_(N+1).
- Latency is NUM_VOICES+1 clocks. busy is high from after E0 until after E_(N+1).
- Minimum tick spacing is NUM_VOICES+2 cycles. A tick coincident with the cycle in which wave_valid is high is accepted.
- wave_valid is never high on two consecutive cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
All scenarios use NUM_VOICES=4, PHASE_W=16, OUT_W=8.
- **Reset:** hold rst for 3 cycles with random inputs → wave_out=0, wave_valid=0, busy=0, overrun=0.
- **Sawtooth:** voice0 mode=10, tune=0x1000; other voices mode=00; tick every 10 cycles.
  - Sample n (n<16) gives wave_out = 4n, i.e. 0x10·n>>2.
  - wave_valid appears exactly 5 clocks after each tick.
- **Pulse and triangle:**
  - All 4 voices pulse, duty=0x80, tune=0x4000 → samples 255, 255, 0, 0, repeating.
  - Voice0 triangle, tune=0x4000, others silent → per-voice w sequence 0x00, 0x80, 0xFF, 0x7F; wave_out = 0x00, 0x20, 0x3F, 0x1F.
- **Overrun:** tick at cycle 0 and again at cycle 2 → exactly one wave_valid, at cycle 5; overrun=1 and stays 1 until rst.
- **Reset mid-sweep:** tick at cycle 0, rst at cycle 3 → no wave_valid. A following tick restarts from all phases zero, so the first sample equals the post-reset first sample.
- **phase_clear:** run sawtooth to phase 0x8000, assert phase_clear for 1 cycle → next sample computed from phase 0; tune=0xFFFF wraps modulo 2^16 with no glitch.
